pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset (word-aligned).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: fetch-ack timeout bound in cycles, legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-007 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port instr  output  32  registered instruction to decode; instr[15:0] drives the sign-extension stage.
REQ-010 SHALL have port instr_valid  output  1  instr holds a valid fetched word.
REQ-011 SHALL have port instr_ready  input  1  consumer accepts instr; also qualifies branch and jump inputs.
REQ-012 SHALL have port branch_taken  input  1  take PC-relative branch.
REQ-013 SHALL have port imm_ext  input  32  sign-extended 16-bit word offset from the sign-extension stage.
REQ-014 SHALL have port jump  input  1  take absolute jump.
REQ-015 SHALL have port jump_target  input  26  jump word index.
REQ-016 SHALL have port pc  output  32  address of the current instruction.
REQ-017 SHALL have port fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, HOLD, ERR.
REQ-019 IDLE SHALL drive imem_req=0 and instr_valid=0, and SHALL go to REQ on the next cycle unconditionally.
REQ-020 REQ SHALL drive imem_req=1 with imem_addr=pc; on imem_ack=1 it SHALL register imem_rdata into instr and go to HOLD.
REQ-021 HOLD SHALL drive instr_valid=1 and imem_req=0; instr and pc SHALL stay stable until instr_ready=1.
REQ-022 In HOLD with instr_ready=1, pc SHALL load next_pc and the FSM SHALL go to REQ; best case is 2 cycles per instruction.
REQ-023 next_pc SHALL be {pc4[31:28], jump_target, 2'b00} if jump=1; otherwise pc4 + {imm_ext[29:0], 2'b00} if branch_taken=1; otherwise pc4. Here pc4 = pc+4.
REQ-024 jump=1 and branch_taken=1 together SHALL resolve as jump.
REQ-025 All address arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFC with no branch or jump SHALL wrap to 0.
REQ-026 branch_taken, jump, imm_ext and jump_target SHALL be ignored except in a HOLD cycle with instr_ready=1.
REQ-027 imem_ack outside REQ SHALL be ignored.
REQ-028 ERR SHALL drive imem_req=0, instr_valid=0 and fetch_err=1, and SHALL be left only by reset.

Reset
REQ-029 While rst=1 the block SHALL enter IDLE with pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0 and the timeout counter=0.
REQ-030 rst asserted mid-fetch (REQ or HOLD) SHALL abandon the outstanding fetch; an imem_ack arriving in the reset cycle SHALL be ignored.

Configuration
REQ-031 Macro PC_FETCH_TIMEOUT_EN defined: a counter SHALL count consecutive REQ cycles without imem_ack, clearing on entry to REQ. When TIMEOUT_CYCLES such cycles have elapsed, the FSM SHALL go to ERR on the next edge.
REQ-032 Macro PC_FETCH_TIMEOUT_EN undefined: REQ SHALL wait indefinitely, fetch_err SHALL be constant 0, ERR SHALL be unreachable, and the counter SHALL be absent.

Verification
REQ-033 Reset, then imem_ack=1 in the first REQ cycle with rdata=32'h2008_0005 -> imem_addr=0; next cycle instr_valid=1 and instr=32'h2008_0005; after instr_ready, pc=4.
REQ-034 pc=32'h100, branch_taken=1, imm_ext=32'hFFFF_FFFE, instr_ready=1 -> pc=32'hFC (pc+4-8).
REQ-035 pc=32'h4000_0010, jump=1, branch_taken=1, jump_target=26'h10 -> pc=32'h4000_0040 (jump wins).
REQ-036 instr_ready held 0 for 5 cycles in HOLD -> instr, pc and instr_valid stable, imem_req=0; pulse on the 6th cycle -> REQ on the next cycle.
REQ-037 pc=32'hFFFF_FFFC, sequential advance -> pc=0; rst during REQ with a coincident imem_ack -> pc=RESET_PC and instr_valid=0.
REQ-038 With PC_FETCH_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no imem_ack -> fetch_err=1 after 4 REQ cycles, imem_req=0, sticky until rst; without the macro -> imem_req held 1 and fetch_err=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: requests one instruction word at pc, holds it for decode,
// then advances pc sequentially, by PC-relative branch, or by absolute jump.
// Optional fetch-ack timeout with sticky error state is enabled by defining PC_FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] imm_ext,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] pc,
    output logic        fetch_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    // Handshake: instr is transferred on any cycle where instr_valid && instr_ready;
    // the imem side completes a read on any cycle where imem_req && imem_ack.
    logic [1:0]  state;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        timeout_hit;

    // The word offset only contributes 30 bits once shifted into a byte offset.
    logic unused_imm;
    assign unused_imm = &{1'b0, imm_ext[31:30]};

    always_comb begin
        pc4     = pc + 32'd4;
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc4 + {imm_ext[29:0], 2'b00};
        end
    end

`ifdef PC_FETCH_TIMEOUT_EN
    logic [7:0] timeout_cnt;

    // Counts consecutive unacknowledged REQ cycles; held at zero outside REQ,
    // so every entry into REQ starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= 8'd0;
        end else if (state != REQ) begin
            timeout_cnt <= 8'd0;
        end else if (!imem_ack) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    assign timeout_hit = (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign fetch_err   = (state == ERR);
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= 32'd0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= HOLD;
                    end else if (timeout_hit) begin
                        state <= ERR;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc    <= next_pc;
                        state <= REQ;
                    end
                end
                ERR: state <= ERR;
            endcase
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential/branch/jump advance, wrap, stall, reset
// abort and fetch timeout; fetched words go through an expected-value queue.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] imm_ext;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] pc;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    pc_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .imm_ext(imm_ext),
        .jump(jump), .jump_target(jump_target),
        .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        imm_ext      = 32'd0;
        jump_target  = 26'd0;
    endtask

    // Entered in a REQ cycle; leaves in the following REQ cycle.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] rd,
                            input logic br, input logic jmp, input logic [31:0] imm,
                            input logic [25:0] jt, input logic [31:0] exp_next, input int lat);
        logic [31:0] e;
        chk("req", imem_req, 32'd1);
        chk("addr", imem_addr, exp_pc);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("req_wait", imem_req, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = rd;
        exp_q.push_back(rd);
        tick();
        imem_ack = 1'b0;
        chk("valid", instr_valid, 32'd1);
        chk("hold_req", imem_req, 32'd0);
        e = exp_q.pop_front();
        chk("instr", instr, e);
        chk("pc_hold", pc, exp_pc);
        branch_taken = br;
        jump         = jmp;
        imm_ext      = imm;
        jump_target  = jt;
        instr_ready  = 1'b1;
        tick();
        clear_ctl();
        chk("pc_next", pc, exp_next);
        chk("req_again", imem_req, 32'd1);
    endtask

    initial begin
        logic [31:0] pcv;
        logic [31:0] held;
        bit          seen;

        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        clear_ctl();
        tick();
        tick();
        chk("rst_req", imem_req, 32'd0);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", fetch_err, 32'd0);

        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = imem_req;
        end
        chk("first_req_seen", 32'(seen), 32'd1);

        do_fetch(32'h0000_0000, 32'h2008_0005, 1'b0, 1'b0, 32'd0, 26'd0, 32'h0000_0004, 0);
        do_fetch(32'h0000_0004, 32'h0800_0040, 1'b0, 1'b1, 32'd0, 26'h40, 32'h0000_0100, 1);
        do_fetch(32'h0000_0100, 32'h1000_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'h0000_00FC, 0);
        do_fetch(32'h0000_00FC, 32'h1111_2222, 1'b1, 1'b0, 32'h0FFF_FFC4, 26'd0, 32'h4000_0010, 2);
        do_fetch(32'h4000_0010, 32'h3333_4444, 1'b1, 1'b1, 32'h0000_1234, 26'h10, 32'h4000_0040, 0);
        do_fetch(32'h4000_0040, 32'h5555_6666, 1'b1, 1'b0, 32'h2FFF_FFEE, 26'd0, 32'hFFFF_FFFC, 0);
        do_fetch(32'hFFFF_FFFC, 32'h7777_8888, 1'b0, 1'b0, 32'd0, 26'd0, 32'h0000_0000, 0);

        // Stall in HOLD with control inputs and stray acks that must be ignored.
        chk("stall_addr", imem_addr, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        tick();
        held = exp_q.pop_front();
        chk("stall_instr0", instr, held);
        for (int i = 0; i < 5; i++) begin
            imem_ack     = 1'b1;
            imem_rdata   = 32'hDEAD_BEEF;
            branch_taken = 1'b1;
            jump         = 1'b1;
            jump_target  = 26'h3FF_FFFF;
            instr_ready  = 1'b0;
            tick();
            chk("stall_valid", instr_valid, 32'd1);
            chk("stall_req", imem_req, 32'd0);
            chk("stall_pc", pc, 32'd0);
            chk("stall_instr", instr, held);
        end
        imem_ack = 1'b0;
        clear_ctl();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("stall_release_req", imem_req, 32'd1);
        chk("stall_release_valid", instr_valid, 32'd0);
        chk("stall_release_pc", pc, 32'd4);

        pcv = 32'd4;
        for (int n = 0; n < 6; n++) begin
            do_fetch(pcv, $urandom, 1'b0, 1'b0, 32'd0, 26'd0, pcv + 32'd4, int'($urandom_range(0, 3)));
            pcv = pcv + 32'd4;
        end

        // Reset in a REQ cycle with a coincident ack.
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_ack = 1'b0;
        chk("mid_rst_pc", pc, 32'd0);
        chk("mid_rst_valid", instr_valid, 32'd0);
        chk("mid_rst_req", imem_req, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_req", imem_req, 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

`ifdef PC_FETCH_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_req", imem_req, 32'd1);
            chk("to_wait_err", fetch_err, 32'd0);
        end
        tick();
        chk("to_err", fetch_err, 32'd1);
        chk("to_req", imem_req, 32'd0);
        chk("to_valid", instr_valid, 32'd0);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_sticky", fetch_err, 32'd1);
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        tick();
        chk("to_rst_clear", fetch_err, 32'd0);
        rst = 1'b0;
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_to_req", imem_req, 32'd1);
            chk("no_to_err", fetch_err, 32'd0);
        end
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
